// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - Request/response channel bundle between the core and dmem_responder
//
// Purpose: groups the valid/ready request channel (load/store command) and the
// valid/ready response channel (load data / fault flag) into one port.
//
// Signals:
//   req_valid    core -> resp  request present
//   req_ready    resp -> core  responder accepts the request this cycle
//   req_we       core -> resp  1 = store, 0 = load
//   req_addr     core -> resp  byte address
//   req_wdata    core -> resp  store data, LSB-justified
//   req_size     core -> resp  00 byte, 01 half, 11 word, 10 reserved
//   req_unsigned core -> resp  zero-extend byte/half loads
//   rsp_valid    resp -> core  response present
//   rsp_ready    core -> resp  core takes the response
//   rsp_rdata    resp -> core  extended load data (0 for stores and faults)
//   rsp_err      resp -> core  access fault
//
// Modports: master = core side, slave = responder side.
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid,
        input  req_ready,
        output req_we,
        output req_addr,
        output req_wdata,
        output req_size,
        output req_unsigned,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        input  req_size,
        input  req_unsigned,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - Data-memory responder: byte-lane stores, sign/zero-extended loads
//
// Purpose: accepts one load/store per request handshake, accesses an internal
// word-wide array (byte-lane write, synchronous read) and returns exactly one
// registered response per request.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (array contents are not reset)
//   bus    dmem_responder_if.slave: req_* request channel, rsp_* response channel
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
//   ADDR_W       request address width (must match the interface)
//
// Build option:
//   DMEM_MISALIGNED_EN  when defined, word-crossing halves/words are split into
//                       two beats (BEAT0 then BEAT1); when undefined they fault.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // First byte address past the end of the array, one bit wider than the
    // address so that addr + size cannot wrap around into range.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(64'(DEPTH_WORDS) * 64'd4);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SZ_B   = 2'b00;
    localparam logic [1:0] SZ_H   = 2'b01;
    localparam logic [1:0] SZ_RSV = 2'b10;
    localparam logic [1:0] SZ_W   = 2'b11;

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    logic [1:0]       state_q,     state_d;
    logic             we_q,        we_d;
    logic             uns_q,       uns_d;
    logic [1:0]       size_q,      size_d;
    logic [1:0]       off_q,       off_d;
    logic [IDX_W-1:0] idx_q,       idx_d;
    logic [31:0]      wdata_q,     wdata_d;
    logic             err_q,       err_d;
    logic             cross_q,     cross_d;
    logic [31:0]      lo_q,        lo_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q,   rsp_err_d;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_q;

    logic accept;

    // req_ready depends only on state and rsp_ready so the core never sees a
    // combinational loop through req_valid.
    assign bus.req_ready = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // ------------------------------------------------------------------
    // Request decode: fault checks are resolved before anything is captured,
    // so a faulting access never reaches the array.
    // ------------------------------------------------------------------
    logic [1:0]      a_off;
    logic [2:0]      a_nbytes;
    logic [ADDR_W:0] a_last;
    logic            a_oor;
    logic            a_rsv;
    logic            a_misal;
    logic            a_cross;
    logic            a_err;
`ifdef DMEM_MISALIGNED_EN
    logic [3:0]      a_span;
`endif

    always_comb begin
        a_off = bus.req_addr[1:0];
        case (bus.req_size)
            SZ_B:    a_nbytes = 3'd1;
            SZ_H:    a_nbytes = 3'd2;
            default: a_nbytes = 3'd4;
        endcase
        a_last = {1'b0, bus.req_addr} + (ADDR_W+1)'(a_nbytes) - (ADDR_W+1)'(1);
        a_oor  = (a_last >= LIMIT);
        a_rsv  = (bus.req_size == SZ_RSV);
`ifdef DMEM_MISALIGNED_EN
        // Any access whose last byte spills past lane 3 needs a second word.
        a_span  = {2'b00, a_off} + {1'b0, a_nbytes};
        a_misal = 1'b0;
        a_cross = (a_span > 4'd4);
`else
        a_misal = ((bus.req_size == SZ_H) && a_off[0]) ||
                  ((bus.req_size == SZ_W) && (a_off != 2'b00));
        a_cross = 1'b0;
`endif
        a_err = a_oor || a_rsv || a_misal;
    end

    // ------------------------------------------------------------------
    // Store lane steering: a 64-bit two-word window so that crossing stores
    // split naturally into a low (first word) and high (second word) half.
    // ------------------------------------------------------------------
    logic [3:0]  mask4;
    logic [7:0]  be8;
    logic [63:0] wd64;

    always_comb begin
        case (size_q)
            SZ_B:    mask4 = 4'b0001;
            SZ_H:    mask4 = 4'b0011;
            default: mask4 = 4'b1111;
        endcase
        be8  = {4'b0000, mask4} << off_q;
        wd64 = {32'h0, wdata_q} << {off_q, 3'b000};
    end

    // ------------------------------------------------------------------
    // Load assembly and extension. In BEAT1 rd_q holds the second word and
    // lo_q the first; otherwise rd_q holds the only word.
    // ------------------------------------------------------------------
    logic [63:0] rd64;
    logic [31:0] raw;
    logic [31:0] ext;

    always_comb begin
        rd64 = (state_q == BEAT1) ? {rd_q, lo_q} : {32'h0, rd_q};
        raw  = 32'(rd64 >> {off_q, 3'b000});
        case (size_q)
            SZ_B:    ext = uns_q ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            SZ_H:    ext = uns_q ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // ------------------------------------------------------------------
    // Array port control. The first word of a load is read on the accept
    // edge so the extended result can be registered one edge later; the
    // second word of a crossing load is read on the BEAT0 edge.
    // ------------------------------------------------------------------
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_be;
    logic             mem_re;
    logic [IDX_W-1:0] mem_ridx;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = idx_q;
        mem_wdata = wd64[31:0];
        mem_be    = be8[3:0];
        mem_re    = 1'b0;
        mem_ridx  = bus.req_addr[IDX_W+1:2];

        if ((state_q == BEAT0) && we_q && !err_q) begin
            mem_we = 1'b1;
        end
        if ((state_q == BEAT1) && we_q) begin
            mem_we    = 1'b1;
            mem_widx  = idx_q + 1'b1;
            mem_wdata = wd64[63:32];
            mem_be    = be8[7:4];
        end

        if (accept && !bus.req_we && !a_err) begin
            mem_re = 1'b1;
        end
        if ((state_q == BEAT0) && !we_q && !err_q && cross_q) begin
            mem_re   = 1'b1;
            mem_ridx = idx_q + 1'b1;
        end
    end

    // Array and its read register carry no reset: contents survive rst_n, and
    // while rst_n is low the state is IDLE so no write can be issued.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        if (mem_re) begin
            rd_q <= mem[mem_ridx];
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and response registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        cross_d     = cross_q;
        lo_d        = lo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            BEAT0: begin
                if (err_q || !cross_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? 32'h0 : ext;
                end else begin
                    state_d = BEAT1;
                    lo_d    = rd_q;
                end
            end
            BEAT1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = we_q ? 32'h0 : ext;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
            end
        endcase

        // Accept may overlap the departing response; it takes priority over
        // the RESP -> IDLE move.
        if (accept) begin
            state_d = BEAT0;
            we_d    = bus.req_we;
            uns_d   = bus.req_unsigned;
            size_d  = bus.req_size;
            off_d   = a_off;
            idx_d   = bus.req_addr[IDX_W+1:2];
            wdata_d = bus.req_wdata;
            err_d   = a_err;
            cross_d = a_cross;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            off_q       <= 2'b00;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            cross_q     <= 1'b0;
            lo_q        <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            size_q      <= size_d;
            off_q       <= off_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            cross_q     <= cross_d;
            lo_q        <= lo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule
